time_entry_loader: RTL and testbench
====================================

# time_entry_loader

Keypad-side producer for the microwave countdown chain: collects BCD digit key presses into a 3-digit M:SS value, validates it, and drives the parallel-load interface (data, active-low load strobe, active-low clear, count enable) of the minutes/tens/seconds counters. It sits between the keypad decoder and the countermod10/countermod6 chain. It watches the chain's `zero` flag to end a cook cycle.

## Interface
Parameters:
- `KEY_START`, default 4'hA: key code that starts cooking.
- `KEY_CLEAR`, default 4'hB: key code that cancels or clears.

Ports:
- `clk`, input, 1: single system clock, rising edge.
- `clr`, input, 1: asynchronous, active-high reset.
- `key_valid`, input, 1: one-cycle strobe; `key_code` is valid.
- `key_code`, input, 4: 0–9 are digits, then `KEY_START`, then `KEY_CLEAR`; 12–15 are ignored.
- `timer_zero`, input, 1: counter chain reads 0:00 (the `zero` of the minutes stage ANDed through the chain).
- `min_ones`, output, 4: minutes digit to the counter data input.
- `sec_tens`, output, 4: tens-of-seconds digit, 0–5 after validation.
- `sec_ones`, output, 4: seconds digit.
- `loadn`, output, 1: active-low parallel-load strobe to all counters.
- `cnt_clrn`, output, 1: active-low counter clear.
- `en`, output, 1: count enable.
- `done`, output, 1: cook finished. It is a level signal.
- `err`, output, 1: rejected START. It is a one-cycle pulse.

## Operation
- States are IDLE, ENTRY, LOAD, RUN and DONE.
- **IDLE**
  - Digits are 0.
  - A digit key shifts into `sec_ones` and moves the block to ENTRY.
  - START pulses `err`.
  - CLEAR has no effect.
- **ENTRY**
  - A digit key shifts left: `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←key.
  - Digit keys after 3 accepted digits are ignored (the digit count saturates at 3).
  - CLEAR zeroes the digits and returns to IDLE.
  - START with `sec_tens`≤5 and a nonzero value goes to LOAD.
  - Any other START pulses `err` and stays in ENTRY, with digits kept.
- **LOAD**
  - `loadn`=0 for exactly one cycle, with the digits stable.
  - The next state is RUN.
- **RUN**
  - `en`=1.
  - Digit and START keys are ignored.
  - CLEAR forces `en`=0 and pulses `cnt_clrn`=0 for one cycle. It also zeroes the digits and goes to IDLE.
  - `timer_zero`=1 forces `en`=0 and goes to DONE.
- **DONE**
  - `done`=1.
  - Any valid key, including codes 12–15, clears `done`, zeroes the digits and goes to IDLE. That key is consumed and is not entered as a digit.
- All outputs are registered.

## Timing
- Reset values: state IDLE, all digits 0, `loadn`=1, `cnt_clrn`=1, `en`=0, `done`=0, `err`=0, digit count 0.
- Reset is asynchronous. Asserting it mid-RUN drops `en` immediately, without a `cnt_clrn` pulse. The counter chain has its own reset.
- Inputs are sampled on the rising edge of `clk`. Outputs update on that same edge.
- A key accepted at edge N is visible on the digit outputs after edge N.
- START accepted at edge N gives:
  - `loadn`=0 during cycle N+1;
  - `en`=1 from edge N+2.
- The counters see load and enable in separate cycles.
- `err` is high for the single cycle after the rejected START edge.
- `timer_zero` is ignored outside RUN. It is also ignored in the first RUN cycle, because the chain is still settling from the load.
- If `key_valid` (CLEAR) and `timer_zero` are both high in the same RUN cycle, `timer_zero` wins: the block goes to DONE and the key is dropped.
- `key_valid` held high for several cycles counts as one key per cycle. Debouncing is upstream.

## Structure
- The shared package holds:
  - the state encoding (3-bit: IDLE=0, ENTRY=1, LOAD=2, RUN=3, DONE=4);
  - `KEY_START` and `KEY_CLEAR` defaults;
  - `MAX_DIGITS`=3;
  - `SEC_TENS_MAX`=5.
- Sub-module `bcd_entry_shift`: a 3×4-bit shift register with a saturating digit count and synchronous zero. It holds no FSM logic.
- The top level holds the FSM, validation, and strobe generation.

## Test plan
- Enter 1, 3, 0, then START:
  - digits read 1:30;
  - `loadn` is low for exactly one cycle;
  - `en` rises the next cycle;
  - drive `timer_zero` after 5 cycles → `en`=0, `done`=1;
  - a key press then returns to IDLE with digits 0.
- Enter 1, 7, 5, then START → `err` pulses one cycle, state stays ENTRY, digits stay 1:75, `loadn` stays 1.
- START in IDLE → `err` pulse. Enter 0, 0, 0, then START → `err` pulse, no load.
- Enter 4, 5, 2, 9 → digits read 4:52 (the 4th digit is ignored). CLEAR → digits 0:00, IDLE.
- In RUN, drive CLEAR → `cnt_clrn` low one cycle, `en`=0, IDLE.
  - Repeat, but drive CLEAR together with `timer_zero` → DONE, no `cnt_clrn` pulse.
- Assert `clr` mid-RUN → `en` drops before the next clock edge, and all outputs take their reset values.

Source files
------------

// File: rtl/time_entry_loader_pkg.sv
// time_entry_loader_pkg
// Shared definitions for the keypad time-entry loader: FSM state encoding,
// default key codes, digit limits and a small key-classification helper.
package time_entry_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0]  KEY_START_DEF = 4'hA;
    localparam logic [3:0]  KEY_CLEAR_DEF = 4'hB;
    localparam int unsigned MAX_DIGITS    = 3;
    localparam int unsigned SEC_TENS_MAX  = 5;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/time_entry_loader_if.sv
// time_entry_loader_if
// Bundles the keypad-side inputs and the counter-chain-side outputs of the
// loader.
//   master : the loader (consumes keys/timer_zero, drives digits and strobes)
//   slave  : the environment (keypad decoder + counter chain)
interface time_entry_loader_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       timer_zero;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       loadn;
    logic       cnt_clrn;
    logic       en;
    logic       done;
    logic       err;

    modport master (
        input  key_valid, key_code, timer_zero,
        output min_ones, sec_tens, sec_ones, loadn, cnt_clrn, en, done, err
    );

    modport slave (
        output key_valid, key_code, timer_zero,
        input  min_ones, sec_tens, sec_ones, loadn, cnt_clrn, en, done, err
    );
endinterface

// File: rtl/time_entry_loader_bcd_entry_shift.sv
// bcd_entry_shift
// Three-digit BCD shift register fed from the right, with a digit count that
// saturates at MAX_DIGITS (further shifts are ignored) and a synchronous zero.
// Ports:
//   clk, clr      : clock, asynchronous active-high reset
//   shift, din    : shift din into d0 (d2<-d1<-d0<-din)
//   zero          : clear digits and count; has priority over shift
//   d2, d1, d0    : minutes, tens-of-seconds, seconds digits
module bcd_entry_shift
    import time_entry_loader_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       shift,
    input  logic       zero,
    input  logic [3:0] din,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);

    logic [1:0] count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d2    <= '0;
            d1    <= '0;
            d0    <= '0;
            count <= '0;
        end else if (zero) begin
            d2    <= '0;
            d1    <= '0;
            d0    <= '0;
            count <= '0;
        end else if (shift && (count < 2'(MAX_DIGITS))) begin
            d2    <= d1;
            d1    <= d0;
            d0    <= din;
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/time_entry_loader.sv
// time_entry_loader
// Collects keypad digits into an M:SS value, validates it on START, then
// parallel-loads the counter chain, enables counting and waits for the chain
// to reach 0:00.
// Ports:
//   clk, clr : clock, asynchronous active-high reset
//   bus      : key_valid/key_code/timer_zero in; digits, loadn, cnt_clrn,
//              en, done, err out (all outputs registered)
module time_entry_loader
    import time_entry_loader_pkg::*;
#(
    parameter logic [3:0] KEY_START = KEY_START_DEF,
    parameter logic [3:0] KEY_CLEAR = KEY_CLEAR_DEF
) (
    input logic                 clk,
    input logic                 clr,
    time_entry_loader_if.master bus
);

    state_t     state;
    logic [3:0] d2, d1, d0;
    logic       loadn_q, cnt_clrn_q, en_q, done_q, err_q;
    logic       dig_key, start_key, clear_key, start_ok;
    logic       run_tz, run_clear, shift, zero;

    assign dig_key   = bus.key_valid && is_digit(bus.key_code);
    assign start_key = bus.key_valid && (bus.key_code == KEY_START);
    assign clear_key = bus.key_valid && (bus.key_code == KEY_CLEAR);
    assign start_ok  = (d1 <= 4'(SEC_TENS_MAX)) && ((d2 | d1 | d0) != 4'd0);

    // en is still low in the first RUN cycle (the load cycle), so it also
    // gates timer_zero while the chain settles; afterwards timer_zero beats CLEAR.
    assign run_tz    = (state == S_RUN) && en_q && bus.timer_zero;
    assign run_clear = (state == S_RUN) && clear_key && !run_tz;

    assign shift = dig_key && ((state == S_IDLE) || (state == S_ENTRY));
    assign zero  = ((state == S_ENTRY) && clear_key) || run_clear ||
                   ((state == S_DONE) && bus.key_valid);

    bcd_entry_shift u_shift (
        .clk   (clk),
        .clr   (clr),
        .shift (shift),
        .zero  (zero),
        .din   (bus.key_code),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= S_IDLE;
            loadn_q    <= 1'b1;
            cnt_clrn_q <= 1'b1;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            cnt_clrn_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (dig_key)
                        state <= S_ENTRY;
                    else if (start_key)
                        err_q <= 1'b1;
                end
                S_ENTRY: begin
                    if (clear_key)
                        state <= S_IDLE;
                    else if (start_key) begin
                        if (start_ok)
                            state <= S_LOAD;
                        else
                            err_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    loadn_q <= 1'b0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (!en_q) begin
                        loadn_q <= 1'b1;
                        if (run_clear) begin
                            cnt_clrn_q <= 1'b0;
                            state      <= S_IDLE;
                        end else
                            en_q <= 1'b1;
                    end else if (run_tz) begin
                        en_q   <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else if (run_clear) begin
                        en_q       <= 1'b0;
                        cnt_clrn_q <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (bus.key_valid) begin
                        done_q <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.min_ones = d2;
    assign bus.sec_tens = d1;
    assign bus.sec_ones = d0;
    assign bus.loadn    = loadn_q;
    assign bus.cnt_clrn = cnt_clrn_q;
    assign bus.en       = en_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_time_entry_loader.sv
// tb_time_entry_loader
// Drives key sequences into time_entry_loader; a behavioural model pushes the
// expected output vector {digits, loadn, cnt_clrn, en, done, err} for every
// clock into a scoreboard queue, popped and compared after the edge.
module tb_time_entry_loader;

    localparam logic [3:0] K_START = 4'hA;
    localparam logic [3:0] K_CLEAR = 4'hB;
    localparam logic [16:0] RST_VEC = {12'h000, 5'b11000};

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    time_entry_loader_if bus_if ();

    time_entry_loader dut (
        .clk (clk),
        .clr (clr),
        .bus (bus_if)
    );

    typedef struct {
        string       tag;
        logic [16:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    // behavioural model
    int          m_st;
    logic [11:0] m_val;
    int          m_n;
    logic        m_loadn, m_clrn, m_en, m_done, m_err, m_first;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {bus_if.min_ones, bus_if.sec_tens, bus_if.sec_ones,
                bus_if.loadn, bus_if.cnt_clrn, bus_if.en, bus_if.done, bus_if.err};
    endfunction

    task automatic model_reset();
        m_st = 0; m_val = '0; m_n = 0;
        m_loadn = 1'b1; m_clrn = 1'b1; m_en = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_first = 1'b0;
    endtask

    task automatic model_clear();
        m_val = '0; m_n = 0; m_st = 0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] code, input logic tz);
        m_err  = 1'b0;
        m_clrn = 1'b1;
        case (m_st)
            0: begin
                if (kv && code < 10) begin
                    m_val = {8'h00, code}; m_n = 1; m_st = 1;
                end else if (kv && code == K_START)
                    m_err = 1'b1;
            end
            1: begin
                if (kv && code < 10) begin
                    if (m_n < 3) begin
                        m_val = {m_val[7:0], code}; m_n++;
                    end
                end else if (kv && code == K_CLEAR)
                    model_clear();
                else if (kv && code == K_START) begin
                    if (m_val[7:4] <= 4'd5 && m_val != 12'h000) m_st = 2;
                    else m_err = 1'b1;
                end
            end
            2: begin
                m_loadn = 1'b0; m_st = 3; m_first = 1'b1;
            end
            3: begin
                if (m_first) begin
                    m_first = 1'b0; m_loadn = 1'b1;
                    if (kv && code == K_CLEAR) begin
                        m_clrn = 1'b0; model_clear();
                    end else
                        m_en = 1'b1;
                end else if (tz) begin
                    m_en = 1'b0; m_done = 1'b1; m_st = 4;
                end else if (kv && code == K_CLEAR) begin
                    m_en = 1'b0; m_clrn = 1'b0; model_clear();
                end
            end
            default: begin
                if (kv) begin
                    m_done = 1'b0; model_clear();
                end
            end
        endcase
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic cycle(input logic kv, input logic [3:0] code, input logic tz, input string tag);
        sb_t e;
        bus_if.key_valid  = kv;
        bus_if.key_code   = code;
        bus_if.timer_zero = tz;
        model_step(kv, code, tz);
        e.tag = tag;
        e.exp = {m_val, m_loadn, m_clrn, m_en, m_done, m_err};
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check(e.tag, dut_vec(), e.exp);
        end
    endtask

    task automatic key(input logic [3:0] code, input string tag);
        cycle(1'b1, code, 1'b0, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, tag);
    endtask

    task automatic enter3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input string tag);
        key(a, tag); key(b, tag); key(c, tag);
    endtask

    initial begin
        bus_if.key_valid  = 1'b0;
        bus_if.key_code   = 4'h0;
        bus_if.timer_zero = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", dut_vec(), RST_VEC);
        clr = 1'b0;

        // 1:30 full cook cycle
        enter3(4'd1, 4'd3, 4'd0, "e130");
        key(K_START, "e130_start");
        idle(2, "e130_load");
        idle(5, "e130_run");
        cycle(1'b0, 4'h0, 1'b1, "e130_tz");
        idle(2, "e130_done");
        key(4'd5, "e130_exit");
        idle(1, "e130_idle");

        // tens > 5 rejected
        enter3(4'd1, 4'd7, 4'd5, "e175");
        key(K_START, "e175_start");
        idle(2, "e175_hold");
        key(K_CLEAR, "e175_clear");

        // START in IDLE, zero value rejected
        key(K_START, "idle_start");
        idle(1, "idle_start_after");
        enter3(4'd0, 4'd0, 4'd0, "e000");
        key(K_START, "e000_start");
        idle(2, "e000_hold");
        key(K_CLEAR, "e000_clear");

        // fourth digit ignored, ignored codes and CLEAR in IDLE
        enter3(4'd4, 4'd5, 4'd2, "e452");
        key(4'd9, "e452_4th");
        key(4'hD, "e452_code13");
        key(K_CLEAR, "e452_clear");
        key(K_CLEAR, "idle_clear");
        key(4'hC, "idle_code12");

        // CLEAR during RUN
        enter3(4'd2, 4'd0, 4'd0, "e200");
        key(K_START, "e200_start");
        idle(3, "e200_run");
        key(4'd7, "e200_digit_run");
        key(K_START, "e200_start_run");
        key(K_CLEAR, "e200_clear");
        idle(2, "e200_after");

        // CLEAR with timer_zero: timer_zero wins
        enter3(4'd2, 4'd0, 4'd0, "e200b");
        key(K_START, "e200b_start");
        idle(3, "e200b_run");
        cycle(1'b1, K_CLEAR, 1'b1, "e200b_clear_tz");
        idle(1, "e200b_done");
        key(4'hF, "e200b_exit");

        // timer_zero in the load cycle is ignored; held key_valid
        enter3(4'd0, 4'd0, 4'd1, "e001");
        key(K_START, "e001_start");
        cycle(1'b0, 4'h0, 1'b1, "e001_loadtz");
        cycle(1'b0, 4'h0, 1'b1, "e001_firstrun_tz");
        cycle(1'b0, 4'h0, 1'b1, "e001_tz");
        key(4'd3, "e001_exit");

        // async reset mid-RUN
        enter3(4'd1, 4'd3, 4'd0, "rst");
        key(K_START, "rst_start");
        idle(3, "rst_run");
        #2 clr = 1'b1;
        #1 check("async_en", {16'h0000, bus_if.en}, 17'h0);
        check("async_vec", dut_vec(), RST_VEC);
        model_reset();
        @(negedge clk);
        check("async_hold", dut_vec(), RST_VEC);
        clr = 1'b0;
        key(4'd6, "post_rst");
        idle(1, "post_rst_idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
